// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_pkg : state encoding and TX mux selects shared by the UART TX path
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_tx_pkg;

  localparam int MUX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Gray-style selects so adjacent phases differ in one bit at the TX mux
  localparam logic [MUX_W-1:0] MUX_IDLE  = 3'b000;
  localparam logic [MUX_W-1:0] MUX_START = 3'b001;
  localparam logic [MUX_W-1:0] MUX_DATA  = 3'b011;
  localparam logic [MUX_W-1:0] MUX_PAR   = 3'b010;
  localparam logic [MUX_W-1:0] MUX_STOP  = 3'b110;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fsm_if : host request / frame-control bundle of the UART TX sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_fsm_if;
  import uart_tx_pkg::*;

  logic             data_valid;
  logic             par_en;
  logic             ready;
  logic             busy;
  logic             load;
  logic             ser_en;
  logic [MUX_W-1:0] mux_sel;

  modport master (
    output data_valid, par_en,
    input  ready, busy, load, ser_en, mux_sel
  );

  modport slave (
    input  data_valid, par_en,
    output ready, busy, load, ser_en, mux_sel
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fsm : UART TX frame sequencer (start, data, optional parity, stop)
// Build option UART_TX_STOP2_EN selects two stop bits.  Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fsm_if.slave  host_if
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             last_stop;
  logic             ready;
  logic             load;
  logic             busy;
  logic             ser_en;
  logic [MUX_W-1:0] mux_sel;

`ifdef UART_TX_STOP2_EN
  logic stop_cnt_q, stop_cnt_d;
  assign last_stop = stop_cnt_q;
`else
  assign last_stop = 1'b1;
`endif

  // Accept window: idle, or the final stop bit for gapless back-to-back frames
  assign ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && last_stop);
  assign load  = ready && host_if.data_valid;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
`ifdef UART_TX_STOP2_EN
    stop_cnt_d = 1'b0;
`endif
    busy    = 1'b1;
    ser_en  = 1'b0;
    mux_sel = MUX_IDLE;

    if (load) begin
      par_d = host_if.par_en;
    end

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (load) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        mux_sel   = MUX_START;
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        mux_sel   = MUX_DATA;
        ser_en    = 1'b1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = par_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        mux_sel = MUX_PAR;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        mux_sel = MUX_STOP;
        if (last_stop) begin
          state_d = load ? ST_START : ST_IDLE;
        end else begin
`ifdef UART_TX_STOP2_EN
          stop_cnt_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
`ifdef UART_TX_STOP2_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  assign host_if.ready   = ready;
  assign host_if.load    = load;
  assign host_if.busy    = busy;
  assign host_if.ser_en  = ser_en;
  assign host_if.mux_sel = mux_sel;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_fsm : scoreboard bench for the UART TX frame sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_fsm;
  import uart_tx_pkg::*;

  localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int FLEN = 1 + DW + STOPS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fsm_if bus ();

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .host_if (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  bit         mon_on = 1'b0;
  logic [3:0] beat_q[$];   // {ser_en, mux_sel} expected per busy cycle
  int         load_q[$];   // expected cycle number of each load strobe
  logic [3:0] mon_exp;
  int         c0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit par, input int at);
    load_q.push_back(at);
    beat_q.push_back({1'b0, MUX_START});
    repeat (DW) beat_q.push_back({1'b1, MUX_DATA});
    if (par) beat_q.push_back({1'b0, MUX_PAR});
    repeat (STOPS) beat_q.push_back({1'b0, MUX_STOP});
  endtask

  // Monitor: consumes expectations whenever the DUT shows a load or a busy cycle
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.load === 1'b1) begin
        if (load_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load at cycle %0d: got load=1 expected 0", cyc);
        end else begin
          check("load_cycle", cyc, load_q.pop_front());
        end
      end
      if (bus.busy === 1'b1) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_busy at cycle %0d: got busy=1 expected 0 (mux_sel=%b)", cyc, bus.mux_sel);
        end else begin
          mon_exp = beat_q.pop_front();
          check("mux_sel", {29'd0, bus.mux_sel}, {29'd0, mon_exp[2:0]});
          check("ser_en",  {31'd0, bus.ser_en},  {31'd0, mon_exp[3]});
        end
      end else begin
        check("idle_busy",    {31'd0, bus.busy},    32'd0);
        check("idle_mux_sel", {29'd0, bus.mux_sel}, {29'd0, MUX_IDLE});
        check("idle_ser_en",  {31'd0, bus.ser_en},  32'd0);
        check("idle_ready",   {31'd0, bus.ready},   32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mux_sel", {29'd0, bus.mux_sel}, {29'd0, MUX_IDLE});
    check("rst_busy",    {31'd0, bus.busy},    32'd0);
    check("rst_ser_en",  {31'd0, bus.ser_en},  32'd0);
    check("rst_load",    {31'd0, bus.load},    32'd0);
    check("rst_ready",   {31'd0, bus.ready},   32'd1);
    rst    = 1'b0;
    mon_on = 1'b1;
    tick;
    tick;

    // Single no-parity frame; ready only in idle and the last stop bit
    c0 = cyc;
    bus.data_valid = 1'b1;
    push_frame(1'b0, c0);
    tick;
    bus.data_valid = 1'b0;
    check("start_ready", {31'd0, bus.ready}, 32'd0);
    repeat (FLEN - 1) tick;
    check("stop_mux_sel", {29'd0, bus.mux_sel}, {29'd0, MUX_STOP});
    check("stop_ready",   {31'd0, bus.ready},   32'd1);
    repeat (3) tick;

    // Parity frame; par_en dropped mid-frame must not remove the parity bit
    bus.data_valid = 1'b1;
    bus.par_en     = 1'b1;
    push_frame(1'b1, cyc);
    tick;
    bus.data_valid = 1'b0;
    repeat (3) tick;
    bus.par_en = 1'b0;
    repeat (FLEN + 2) tick;

    // Back-to-back: valid held across three accepts
    c0 = cyc;
    bus.data_valid = 1'b1;
    for (int k = 0; k < 3; k++) push_frame(1'b0, c0 + k * FLEN);
    repeat (2 * FLEN + 1) tick;
    bus.data_valid = 1'b0;
    repeat (FLEN + 2) tick;

    // Request during DATA is ignored and does not stretch the frame
    c0 = cyc;
    bus.data_valid = 1'b1;
    push_frame(1'b0, c0);
    tick;
    bus.data_valid = 1'b0;
    repeat (3) tick;
    bus.data_valid = 1'b1;
    check("midframe_ready", {31'd0, bus.ready}, 32'd0);
    check("midframe_load",  {31'd0, bus.load},  32'd0);
    tick;
    bus.data_valid = 1'b0;
    repeat (FLEN - 4) tick;
    check("after_ignored_busy", {31'd0, bus.busy},    32'd0);
    check("after_ignored_mux",  {29'd0, bus.mux_sel}, {29'd0, MUX_IDLE});
    repeat (2) tick;

    // Reset during the third data bit abandons the frame
    c0 = cyc;
    bus.data_valid = 1'b1;
    load_q.push_back(c0);
    beat_q.push_back({1'b0, MUX_START});
    repeat (3) beat_q.push_back({1'b1, MUX_DATA});
    tick;
    bus.data_valid = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    check("mrst_mux_sel", {29'd0, bus.mux_sel}, {29'd0, MUX_IDLE});
    check("mrst_busy",    {31'd0, bus.busy},    32'd0);
    check("mrst_ready",   {31'd0, bus.ready},   32'd1);
    check("mrst_ser_en",  {31'd0, bus.ser_en},  32'd0);
    rst = 1'b0;
    tick;
    bus.data_valid = 1'b1;
    push_frame(1'b0, cyc);
    tick;
    bus.data_valid = 1'b0;
    repeat (FLEN + 2) tick;

`ifdef UART_TX_STOP2_EN
    // Request in the first stop bit is refused; second stop bit opens the window
    c0 = cyc;
    bus.data_valid = 1'b1;
    push_frame(1'b0, c0);
    tick;
    bus.data_valid = 1'b0;
    repeat (DW + 1) tick;
    check("stop1_mux_sel", {29'd0, bus.mux_sel}, {29'd0, MUX_STOP});
    check("stop1_ready",   {31'd0, bus.ready},   32'd0);
    bus.data_valid = 1'b1;
    tick;
    bus.data_valid = 1'b0;
    check("stop2_mux_sel", {29'd0, bus.mux_sel}, {29'd0, MUX_STOP});
    check("stop2_ready",   {31'd0, bus.ready},   32'd1);
    tick;
    check("stop2_idle_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) tick;
`endif

    repeat (3) tick;
    check("beats_left", beat_q.size(), 32'd0);
    check("loads_left", load_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
